// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
//   640x480@60 Hz raster timing generator with a sync/blank delay line. The
//   delay line matches the image renderer's ROM and register latency, so
//   sync, blank and colour for one pixel reach the VGA DAC pins together.
//
// Ports
//   VGA_clk      in   pixel clock (25.175 MHz nominal)
//   rst          in   asynchronous, active-high reset
//   RGB[23:0]    in   renderer pixel colour {R,G,B}; it belongs to the X/Y
//                     presented PIPE_DELAY clocks earlier
//   test_mode    in   colour-bar select (only with VGA_TEST_PATTERN_EN)
//   X, Y         out  pixel / line counters, zero-extended to 32-bit signed
//   display_on   out  X/Y inside the visible area
//   frame_start  out  high while X==0 and Y==0
//   line_start   out  high while X==0
//   VGA_HS/VS    out  active-low syncs, delayed PIPE_DELAY+1 clocks from X/Y
//   VGA_BLANK_N  out  delayed display_on
//   VGA_SYNC_N   out  tied low
//   VGA_R/G/B    out  colour, forced to 0 while blanked
//
// Build option
//   VGA_TEST_PATTERN_EN: adds test_mode and an eight-bar colour generator
//   (bar index X/80) that travels through the same delay line.

module vga_timing_ctrl #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic               VGA_clk,
    input  logic               rst,
    input  logic [23:0]        RGB,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               test_mode,
`endif
    output logic signed [31:0] X,
    output logic signed [31:0] Y,
    output logic               display_on,
    output logic               frame_start,
    output logic               line_start,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic               VGA_SYNC_N,
    output logic [7:0]         VGA_R,
    output logic [7:0]         VGA_G,
    output logic [7:0]         VGA_B
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_C  = HW'(H_VISIBLE);
    localparam logic [VW-1:0] V_VIS_C  = VW'(V_VISIBLE);
    localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    // Counters and the X/Y-aligned flags
    logic [HW-1:0] x_q, x_d;
    logic [VW-1:0] y_q, y_d;
    logic          display_on_q, display_on_d;
    logic          frame_start_q, line_start_q;

    // Delay line: stage 0 trails X/Y by one clock, stage PIPE_DELAY-1 by
    // PIPE_DELAY clocks, which is when the matching RGB arrives.
    logic [PIPE_DELAY-1:0] hs_pipe_q;
    logic [PIPE_DELAY-1:0] vs_pipe_q;
    logic [PIPE_DELAY-1:0] blank_pipe_q;
    logic                  hs_raw, vs_raw;

    // Pin registers
    logic        vga_hs_q, vga_vs_q, blank_n_q;
    logic [23:0] rgb_q;
    logic [23:0] colour_d;

`ifdef VGA_TEST_PATTERN_EN
    logic [PIPE_DELAY-1:0][2:0] bar_pipe_q;
    logic [2:0]                 bar_d;
    logic [2:0]                 bar_out;

    // X/80 as a compare chain; only 0..7 matters inside the visible area
    always_comb begin
        bar_d = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (x_q >= HW'(i * 80)) bar_d = 3'(i);
        end
    end

    assign bar_out = bar_pipe_q[PIPE_DELAY-1];
`endif

    always_comb begin
        x_d = x_q + HW'(1);
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + VW'(1);
        end
        display_on_d = (x_d < H_VIS_C) && (y_d < V_VIS_C);
    end

    // Raw syncs are decoded from the registered counters, so they share
    // display_on's alignment with X/Y before entering the delay line.
    assign hs_raw = !((x_q >= HS_START) && (x_q <= HS_END));
    assign vs_raw = !((y_q >= VS_START) && (y_q <= VS_END));

    always_comb begin
        colour_d = RGB;
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) colour_d = {{8{bar_out[2]}}, {8{bar_out[1]}}, {8{bar_out[0]}}};
`endif
    end

    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            display_on_q  <= 1'b0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            hs_pipe_q     <= '1;
            vs_pipe_q     <= '1;
            blank_pipe_q  <= '0;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            blank_n_q     <= 1'b0;
            rgb_q         <= '0;
`ifdef VGA_TEST_PATTERN_EN
            bar_pipe_q    <= '0;
`endif
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            display_on_q  <= display_on_d;
            frame_start_q <= (x_d == '0) && (y_d == '0);
            line_start_q  <= (x_d == '0);

            hs_pipe_q[0]    <= hs_raw;
            vs_pipe_q[0]    <= vs_raw;
            blank_pipe_q[0] <= display_on_q;
`ifdef VGA_TEST_PATTERN_EN
            bar_pipe_q[0]   <= bar_d;
`endif
            for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
                hs_pipe_q[i]    <= hs_pipe_q[i-1];
                vs_pipe_q[i]    <= vs_pipe_q[i-1];
                blank_pipe_q[i] <= blank_pipe_q[i-1];
`ifdef VGA_TEST_PATTERN_EN
                bar_pipe_q[i]   <= bar_pipe_q[i-1];
`endif
            end

            // Colour is captured on the same edge as the last stage leaves
            // the delay line, so all pins change together.
            vga_hs_q  <= hs_pipe_q[PIPE_DELAY-1];
            vga_vs_q  <= vs_pipe_q[PIPE_DELAY-1];
            blank_n_q <= blank_pipe_q[PIPE_DELAY-1];
            rgb_q     <= blank_pipe_q[PIPE_DELAY-1] ? colour_d : '0;
        end
    end

    assign X           = {{(32-HW){1'b0}}, x_q};
    assign Y           = {{(32-VW){1'b0}}, y_q};
    assign display_on  = display_on_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;
    assign VGA_HS      = vga_hs_q;
    assign VGA_VS      = vga_vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl
//   Directed bench for vga_timing_ctrl. Horizontal timing is the real 640-wide
//   line; the frame is shortened to 4 visible lines (V_FRONT 1, V_SYNC 2,
//   V_BACK 1 -> 8 lines, 6400 clocks) to keep runs short. PIPE_DELAY is 2, so
//   the pins trail X/Y by 3 clocks. Expected values come from closed-form
//   position arithmetic on the cycle number since reset release.

module tb_vga_timing_ctrl;

    localparam int unsigned HT    = 800;
    localparam int unsigned VV    = 4;
    localparam int unsigned VT    = 8;
    localparam int unsigned FRAME = HT * VT;
    localparam int unsigned D     = 3;

    logic               VGA_clk = 1'b0;
    logic               rst = 1'b1;
    logic [23:0]        RGB = 24'h70C5CE;
`ifdef VGA_TEST_PATTERN_EN
    logic               test_mode = 1'b0;
`endif
    logic signed [31:0] X, Y;
    logic               display_on, frame_start, line_start;
    logic               VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [7:0]         VGA_R, VGA_G, VGA_B;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    vga_timing_ctrl #(
        .V_VISIBLE (VV),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1),
        .PIPE_DELAY(2)
    ) dut (
        .VGA_clk    (VGA_clk),
        .rst        (rst),
        .RGB        (RGB),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode  (test_mode),
`endif
        .X          (X),
        .Y          (Y),
        .display_on (display_on),
        .frame_start(frame_start),
        .line_start (line_start),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N (VGA_SYNC_N),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B)
    );

    always #5 VGA_clk = ~VGA_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Stimulus: constant colour for the first frame after release, then a
    // per-pixel pattern keyed to the X it belongs to (driven 2 clocks late).
    function automatic logic [23:0] rgb_for(input int unsigned k);
        int unsigned x;
        if (k < FRAME) return 24'h70C5CE;
        x = (k - 2) % HT;
        return {8'(x), 8'(x >> 2), 8'h5A};
    endfunction

    function automatic logic [23:0] bar_rgb(input int unsigned x);
        logic [2:0] b;
        b = 3'(x / 80);
        return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    endfunction

    // Runs ncyc clocks from reset release; cycle c is sampled at the negedge
    // following the c-th rising edge after release.
    task automatic run_window(input int unsigned ncyc, input bit tm, input string tag);
        int unsigned xy_bad = 0, flag_bad = 0, pin_bad = 0, rgb_bad = 0;
        int unsigned don_cnt = 0, ls_cnt = 0, fs_cnt = 0, fs_first = 0, fs_prev = 0, fs_gap_bad = 0;
        int unsigned hs_fall = 0, hs_rise = 0, vs_fall = 0, vs_low = 0;
        int unsigned ex, ey, kx, ky;
        logic        prev_hs = 1'b1, prev_vs = 1'b1;
        logic        ehs, evs, ebl, eon;
        logic [23:0] erg, pins;
        RGB = rgb_for(0);
        for (int unsigned c = 1; c <= ncyc; c++) begin
            @(posedge VGA_clk);
            @(negedge VGA_clk);
            ex  = c % HT;
            ey  = (c / HT) % VT;
            eon = (ex < 640) && (ey < VV);
            if (c == 1) begin
                check({tag, "_first_X"}, X, 32'd1);
                check({tag, "_first_Y"}, Y, 32'd0);
                check({tag, "_first_on"}, {31'd0, display_on}, 32'd1);
            end
            if (X !== ex || Y !== ey) xy_bad++;
            if (display_on !== eon || line_start !== (ex == 0) ||
                frame_start !== (ex == 0 && ey == 0)) flag_bad++;
            if (c <= FRAME) begin
                if (display_on) don_cnt++;
                if (line_start) ls_cnt++;
            end
            if (frame_start) begin
                if (fs_cnt == 0) fs_first = c;
                else if (c - fs_prev != FRAME) fs_gap_bad++;
                fs_prev = c;
                fs_cnt++;
            end

            // Pins: first D cycles still carry the reset-state pipeline
            if (c <= D) begin
                ehs = 1'b1; evs = 1'b1; ebl = 1'b0; erg = '0;
            end else begin
                kx  = (c - D) % HT;
                ky  = ((c - D) / HT) % VT;
                ehs = !(kx >= 656 && kx <= 751);
                evs = !(ky >= 5 && ky <= 6);
                ebl = (kx < 640) && (ky < VV);
                erg = !ebl ? 24'h0 : (tm ? bar_rgb(kx) : rgb_for(c - 1));
            end
            pins = {VGA_R, VGA_G, VGA_B};
            if (VGA_HS !== ehs || VGA_VS !== evs || VGA_BLANK_N !== ebl || VGA_SYNC_N !== 1'b0) pin_bad++;
            if (pins !== erg) rgb_bad++;

            if (prev_hs && !VGA_HS && hs_fall == 0) hs_fall = c;
            if (!prev_hs && VGA_HS && hs_rise == 0) hs_rise = c;
            if (prev_vs && !VGA_VS && vs_fall == 0) vs_fall = c;
            if (c > D && c <= FRAME + D && !VGA_VS) vs_low++;
            prev_hs = VGA_HS;
            prev_vs = VGA_VS;

            // Line 1 boundary pixels (line 0 pixel 0 is lost to reset)
            if (c == HT + D)       begin
                check({tag, "_px0"}, {8'd0, pins}, tm ? 32'h000000 : 32'h70C5CE);
                check({tag, "_px0_blank"}, {31'd0, VGA_BLANK_N}, 32'd1);
            end
            if (c == HT + D + 80)  check({tag, "_px80"},  {8'd0, pins}, tm ? 32'h0000FF : 32'h70C5CE);
            if (c == HT + D + 560) check({tag, "_px560"}, {8'd0, pins}, tm ? 32'hFFFFFF : 32'h70C5CE);
            if (c == HT + D + 639) check({tag, "_px639"}, {8'd0, pins}, tm ? 32'hFFFFFF : 32'h70C5CE);
            if (c == HT + D + 640) begin
                check({tag, "_px640"}, {8'd0, pins}, 32'h0);
                check({tag, "_px640_blank"}, {31'd0, VGA_BLANK_N}, 32'd0);
            end
            RGB = rgb_for(c);
        end
        check({tag, "_xy_errs"},      xy_bad,     0);
        check({tag, "_flag_errs"},    flag_bad,   0);
        check({tag, "_pin_errs"},     pin_bad,    0);
        check({tag, "_rgb_errs"},     rgb_bad,    0);
        check({tag, "_on_count"},     don_cnt,    640 * VV);
        check({tag, "_ls_count"},     ls_cnt,     VT);
        check({tag, "_fs_first"},     fs_first,   FRAME);
        check({tag, "_fs_gap_errs"},  fs_gap_bad, 0);
        check({tag, "_fs_count"},     fs_cnt,     ncyc / FRAME);
        check({tag, "_hs_fall"},      hs_fall,    656 + D);
        check({tag, "_hs_rise"},      hs_rise,    752 + D);
        check({tag, "_vs_fall"},      vs_fall,    5 * HT + D);
        check({tag, "_vs_low"},       vs_low,     2 * HT);
    endtask

    initial begin
        // Reset held 10 clocks
        repeat (10) @(posedge VGA_clk);
        @(negedge VGA_clk);
        check("rst_X", X, 0);
        check("rst_Y", Y, 0);
        check("rst_flags", {29'd0, display_on, frame_start, line_start}, 0);
        check("rst_sync", {29'd0, VGA_HS, VGA_VS, VGA_BLANK_N}, 32'b110);
        check("rst_sync_n", {31'd0, VGA_SYNC_N}, 0);
        check("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 0);
        rst = 1'b0;
        run_window(2 * FRAME + 10, 1'b0, "run");

        // Asynchronous reset in the middle of a vsync line with hsync active
        for (int unsigned i = 0; i < 2 * FRAME && !(X == 700 && Y == 5); i++) @(negedge VGA_clk);
        check("mid_X_found", X, 700);
        check("mid_pins_pre", {30'd0, VGA_HS, VGA_VS}, 0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_XY", {X[15:0], Y[15:0]}, 0);
        check("mid_rst_sync", {29'd0, VGA_HS, VGA_VS, VGA_BLANK_N}, 32'b110);
        check("mid_rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 0);
        @(posedge VGA_clk);
        @(negedge VGA_clk);
        rst = 1'b0;
        run_window(FRAME + 10, 1'b0, "mid");

`ifdef VGA_TEST_PATTERN_EN
        test_mode = 1'b1;
        rst = 1'b1;
        @(posedge VGA_clk);
        @(negedge VGA_clk);
        rst = 1'b0;
        run_window(FRAME + 10, 1'b1, "bars");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
